// File: rtl/sync_filter_edge.sv
// sync_filter_edge: multi-channel synchronizer with consecutive-cycle glitch filter and edge pulses
//   clk        system clock
//   rst        asynchronous reset, active-high
//   async_in   [WIDTH] asynchronous inputs
//   sync_out   [WIDTH] last synchronizer stage
//   filt_out   [WIDTH] debounced value
//   rise_pulse [WIDTH] one-cycle pulse on filt_out 0->1
//   fall_pulse [WIDTH] one-cycle pulse on filt_out 1->0
//   any_change one-cycle pulse when any rise/fall pulse is set
module sync_filter_edge #(
    parameter int               WIDTH      = 1,
    parameter int               STAGES     = 2,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter int               FILTER_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);
    localparam int            CW   = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);
    if (STAGES < 2) begin : g_bad_stages
        $error("sync_filter_edge: STAGES must be >= 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("sync_filter_edge: FILTER_LEN must be >= 1");
    end
    logic [WIDTH-1:0] chain [STAGES];
    logic [CW-1:0]    cnt   [WIDTH];
    logic [WIDTH-1:0] hit;
    assign sync_out = chain[STAGES-1];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int k = 0; k < STAGES; k++) chain[k] <= RST_VAL;
        end else begin
            chain[0] <= async_in;
            for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
        end
    // hit: channel has mismatched for FILTER_LEN consecutive cycles, so filt_out takes sync_out now
    always_comb begin
        hit = '0;
        for (int k = 0; k < WIDTH; k++)
            hit[k] = (sync_out[k] != filt_out[k]) && (cnt[k] == LAST);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int k = 0; k < WIDTH; k++) cnt[k] <= '0;
            filt_out   <= RST_VAL;
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
        end else begin
            for (int k = 0; k < WIDTH; k++)
                cnt[k] <= (sync_out[k] == filt_out[k] || hit[k]) ? '0 : cnt[k] + 1'b1;
            filt_out   <= (filt_out & ~hit) | (sync_out & hit);
            rise_pulse <= hit & sync_out;
            fall_pulse <= hit & ~sync_out;
            any_change <= |hit;
        end
endmodule
